// File: rtl/data_mem_responder.sv
// data_mem_responder: word-wide SRAM with fixed wait states for the MEM stage.
// Stalls the pipeline through freeze until the one-cycle ready pulse.
module data_mem_responder #(
    parameter int WAIT_CYCLES = 4,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        addr_err,
    output logic        freeze
);

    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE = 32'(BASE_ADDR);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  count;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH];

    logic start;
    logic access;
    logic ready_nxt;
    logic err_nxt;

    // Unsigned wrap makes addresses below BASE land far out of range.
    assign offset   = addr_q - BASE;
    assign in_range = offset < SPAN;
    assign idx      = offset[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (MEM_R_EN || MEM_W_EN) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (count == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        start     = 1'b0;
        access    = 1'b0;
        ready_nxt = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                start = MEM_R_EN || MEM_W_EN;
            end
            BUSY: begin
                access    = count == LAST;
                ready_nxt = access;
                err_nxt   = access && !in_range;
            end
            default: begin
                start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            write_q  <= 1'b0;
            rdata    <= 32'd0;
            ready    <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            ready    <= ready_nxt;
            addr_err <= err_nxt;
            if (start) begin
                addr_q  <= address;
                wdata_q <= wdata;
                write_q <= MEM_W_EN;
                count   <= 4'd0;
            end else if (state == BUSY) begin
                count <= count + 4'd1;
            end
            if (access && !write_q) begin
                rdata <= in_range ? mem[idx] : 32'd0;
            end
        end
    end

    // Array is never cleared; reset only blocks an in-flight commit.
    always_ff @(posedge clk) begin
        if (!rst && access && write_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

    assign freeze = (MEM_R_EN || MEM_W_EN) && !ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors against three wait-state builds.
// Unit 0 uses 4 wait states, unit 1 uses 1, unit 2 uses 15.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren  [3];
    logic        wen  [3];
    logic [31:0] addr [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic        rdy  [3];
    logic        aerr [3];
    logic        frz  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 4 : ((g == 1) ? 1 : 15);
        data_mem_responder #(
            .WAIT_CYCLES(WC),
            .DEPTH(64),
            .BASE_ADDR(1024)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .MEM_R_EN(ren[g]),
            .MEM_W_EN(wen[g]),
            .address(addr[g]),
            .wdata(wdat[g]),
            .rdata(rdat[g]),
            .ready(rdy[g]),
            .addr_err(aerr[g]),
            .freeze(frz[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the responder idle.
    task automatic xact(input int u, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int wc, input string tag,
                        output logic [31:0] rd, output logic err);
        int lat;
        int fz;
        lat = -1;
        fz  = 0;
        rd  = 32'hFFFF_FFFF;
        err = 1'b1;
        ren[u]  = r;
        wen[u]  = w;
        addr[u] = a;
        wdat[u] = d;
        for (int n = 0; n < wc + 4 && lat < 0; n++) begin
            @(negedge clk);
            if (frz[u]) fz++;
            if (rdy[u]) begin
                lat = n;
                rd  = rdat[u];
                err = aerr[u];
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(wc + 1));
        check({tag, "_frz"}, 32'(fz), 32'(wc + 1));
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int u);
        ren[u] = 1'b0;
        wen[u] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        err;
    int          pulses;

    initial begin
        for (int i = 0; i < 3; i++) begin
            ren[i]  = 1'b0;
            wen[i]  = 1'b0;
            addr[i] = 32'd0;
            wdat[i] = 32'd0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(rdy[0]), 32'd0);
        check("rst_err", 32'(aerr[0]), 32'd0);
        check("rst_rdata", rdat[0], 32'd0);
        check("rst_freeze", 32'(frz[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        xact(0, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4, "wr8", rd, err);
        check("wr8_err", 32'(err), 32'd0);
        drop(0);
        xact(0, 1'b1, 1'b0, 32'd1032, 32'd0, 4, "rd8", rd, err);
        check("rd8_data", rd, 32'hDEAD_BEEF);
        check("rd8_err", 32'(err), 32'd0);
        drop(0);

        xact(0, 1'b0, 1'b1, 32'd1024, 32'h1111_1111, 4, "wr0", rd, err);
        drop(0);
        xact(0, 1'b0, 1'b1, 32'd1028, 32'h2222_2222, 4, "wr4", rd, err);
        drop(0);
        xact(0, 1'b1, 1'b0, 32'd1024, 32'd0, 4, "b2b0", rd, err);
        check("b2b0_data", rd, 32'h1111_1111);
        xact(0, 1'b1, 1'b0, 32'd1028, 32'd0, 4, "b2b1", rd, err);
        check("b2b1_data", rd, 32'h2222_2222);
        drop(0);

        xact(0, 1'b1, 1'b0, 32'd1000, 32'd0, 4, "oor_rd", rd, err);
        check("oor_rd_data", rd, 32'd0);
        check("oor_rd_err", 32'(err), 32'd1);
        drop(0);
        xact(0, 1'b0, 1'b1, 32'd1276, 32'h7777_7777, 4, "wr252", rd, err);
        check("wr252_err", 32'(err), 32'd0);
        drop(0);
        xact(0, 1'b0, 1'b1, 32'd1280, 32'h0000_0055, 4, "oor_wr", rd, err);
        check("oor_wr_err", 32'(err), 32'd1);
        drop(0);
        xact(0, 1'b1, 1'b0, 32'd1276, 32'd0, 4, "rd252", rd, err);
        check("rd252_data", rd, 32'h7777_7777);
        drop(0);
        xact(0, 1'b1, 1'b0, 32'd1024, 32'd0, 4, "rd0_keep", rd, err);
        check("rd0_keep_data", rd, 32'h1111_1111);
        drop(0);

        xact(0, 1'b0, 1'b1, 32'd1040, 32'h0BAD_F00D, 4, "wr16", rd, err);
        drop(0);
        wen[0]  = 1'b1;
        addr[0] = 32'd1040;
        wdat[0] = 32'h1234_5678;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst    = 1'b1;
        wen[0] = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rdy[0]) pulses++;
        end
        check("midrst_pulses", 32'(pulses), 32'd0);
        check("midrst_rdata", rdat[0], 32'd0);
        check("midrst_freeze", 32'(frz[0]), 32'd0);
        @(posedge clk);
        #1;
        xact(0, 1'b1, 1'b0, 32'd1040, 32'd0, 4, "rd16", rd, err);
        check("rd16_data", rd, 32'h0BAD_F00D);
        drop(0);

        xact(0, 1'b1, 1'b1, 32'd1036, 32'hA5A5_A5A5, 4, "both", rd, err);
        check("both_rdata", rd, 32'h0BAD_F00D);
        check("both_err", 32'(err), 32'd0);
        drop(0);
        xact(0, 1'b1, 1'b0, 32'd1036, 32'd0, 4, "rd12", rd, err);
        check("rd12_data", rd, 32'hA5A5_A5A5);
        drop(0);

        xact(1, 1'b0, 1'b1, 32'd1032, 32'hCAFE_0001, 1, "w1_wr", rd, err);
        drop(1);
        xact(1, 1'b1, 1'b0, 32'd1032, 32'd0, 1, "w1_rd", rd, err);
        check("w1_data", rd, 32'hCAFE_0001);
        drop(1);
        xact(2, 1'b0, 1'b1, 32'd1032, 32'hCAFE_000F, 15, "w15_wr", rd, err);
        drop(2);
        xact(2, 1'b1, 1'b0, 32'd1032, 32'd0, 15, "w15_rd", rd, err);
        check("w15_data", rd, 32'hCAFE_000F);
        drop(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface: serves the MEM_R_EN/MEM_W_EN requests the pipeline issues from its memory stage.
- Models a multi-cycle word-wide SRAM with a fixed number of wait states.
- Returns read data and a one-cycle ready pulse.
- Drives the pipeline-wide freeze while an access is outstanding. It sits beside MEM_Stage and replaces the constant-zero freeze.

Parameters:
- WAIT_CYCLES, 4, wait-state cycles per access (legal range 1..15).
- DEPTH, 64, number of 32-bit words in the array (power of two).
- BASE_ADDR, 1024, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- MEM_R_EN  input  1  read request, held stable by the initiator until ready
- MEM_W_EN  input  1  write request, held stable until ready
- address  input  32  byte address; bits [1:0] ignored
- wdata  input  32  write data (Val_Rm of the store)
- rdata  output  32  read data, valid while ready=1, held until the next read completes
- ready  output  1  one-cycle completion pulse
- addr_err  output  1  pulses with ready when the address was out of range
- freeze  output  1  combinational: (MEM_R_EN|MEM_W_EN) & ~ready

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, counter=0, rdata=0, ready=0, addr_err=0.
  - Array contents are not cleared.
  - Reset mid-access abandons the access; a pending write is NOT committed.
- Word index: (address - BASE_ADDR) >> 2.
  - In range iff BASE_ADDR <= address < BASE_ADDR + 4*DEPTH.
  - Subtraction is 32-bit unsigned.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If MEM_R_EN|MEM_W_EN, latch address, wdata and op (write if MEM_W_EN, else read), clear counter, go BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Counter increments each cycle.
  - When counter == WAIT_CYCLES-1, at that edge perform the access and go DONE:
    - write: array[idx] <= latched wdata.
    - read: rdata <= array[idx].
- DONE:
  - ready=1 and addr_err=(out of range) for exactly this cycle; go IDLE next edge.
- Latency: request first seen in cycle 0 gives ready in cycle WAIT_CYCLES+1.
  - freeze is high in cycles 0..WAIT_CYCLES and low in cycle WAIT_CYCLES+1.
- The initiator advances on the edge ending the DONE cycle.
  - A request still asserted in the following IDLE cycle is a new access; there is no merging.
- Both enables high: treated as a write; the read is ignored and rdata is unchanged.
- Out-of-range address:
  - write is dropped (array unchanged).
  - read returns rdata=0.
  - addr_err=1 together with ready.
- Inputs are sampled only in IDLE; changes during BUSY or DONE are ignored.
- ready and addr_err are registered outputs; freeze is the only combinational output.
- Write-then-read of the same word returns the new data (the write committed before DONE).

Test Plan:
- Write then read:
  - Stimulus: rst 2 cycles; MEM_W_EN=1, address=1024+8, wdata=0xDEADBEEF held until ready; then MEM_R_EN=1, same address.
  - Required response: ready pulses exactly 5 cycles after each request starts; freeze high for 5 cycles each time; read gives rdata=0xDEADBEEF with addr_err=0.
- Back-to-back:
  - Stimulus: reads of 1024+0 and 1024+4 with the request held continuously.
  - Required response: two separate 6-cycle transactions; ready high for exactly 1 cycle each; one IDLE cycle between them with freeze=1.
- Out of range:
  - Stimulus: read at address 1000; write 0x55 to address 1024+256.
  - Required response: both give ready with addr_err=1; read rdata=0; array unchanged (a subsequent read of 1024+252 returns its prior value).
- Reset mid-access:
  - Stimulus: write 0x12345678 to 1024+16; assert rst in BUSY cycle 2.
  - Required response: ready never pulses; state IDLE; a later read of 1024+16 returns the old contents, not 0x12345678.
- Both enables:
  - Stimulus: MEM_R_EN=MEM_W_EN=1, address 1024+12, wdata=0xA5A5A5A5.
  - Required response: write performed; rdata keeps its previous value; a subsequent read returns 0xA5A5A5A5.
- Parameter sweep:
  - Stimulus: WAIT_CYCLES=1 and WAIT_CYCLES=15.
  - Required response: ready in cycle 2 and cycle 16 respectively; freeze low for the DONE cycle.
